// File: rtl/alu_seq_ctrl_if.sv
// Bus between the operand sequencer, its switch/button inputs, the ALU and the display.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface alu_seq_ctrl_if #(
  parameter int N = 8
);
  logic [N-1:0] data_in;
  logic [3:0]   op_sel;
  logic         enter;
  logic         undo;
  logic [3:0]   alu_button;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [N-1:0] alu_resultado;
  logic         alu_overflow;
  logic         alu_underflow;
  logic         alu_valid;
  logic [N-1:0] result;
  logic         result_valid;
  logic         error;
  logic [2:0]   state_out;
  logic [N-1:0] display_value;

  modport master (
    output data_in, op_sel, enter, undo,
    output alu_resultado, alu_overflow, alu_underflow, alu_valid,
    input  alu_button, alu_a, alu_b,
    input  result, result_valid, error, state_out, display_value
  );

  modport slave (
    input  data_in, op_sel, enter, undo,
    input  alu_resultado, alu_overflow, alu_underflow, alu_valid,
    output alu_button, alu_a, alu_b,
    output result, result_valid, error, state_out, display_value
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Operand/op sequencer for the 4-op ALU: collects A, B and a one-hot op from the
// switches, fires the ALU for a single cycle and holds the result for the display.
module alu_seq_ctrl #(
  parameter int N = 8
) (
  input logic            clk_i,
  input logic            reset_i,
  alu_seq_ctrl_if.slave  bus
);

  localparam logic [2:0] S_A    = 3'd0;
  localparam logic [2:0] S_B    = 3'd1;
  localparam logic [2:0] S_OP   = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_SHOW = 3'd4;

  logic [2:0]   state_q,  state_d;
  logic [N-1:0] regA_q,   regA_d;
  logic [N-1:0] regB_q,   regB_d;
  logic [3:0]   regOp_q,  regOp_d;
  logic [N-1:0] result_q, result_d;
  logic         error_q,  error_d;
  logic         opOneHot;

  // alu_valid carries no information beyond the op select we drive ourselves
  logic unusedAluValid;
  assign unusedAluValid = bus.alu_valid;

  assign opOneHot = (bus.op_sel != 4'd0) && ((bus.op_sel & (bus.op_sel - 4'd1)) == 4'd0);

  // undo is tested before enter in every state so it wins a simultaneous press
  always_comb begin
    state_d  = state_q;
    regA_d   = regA_q;
    regB_d   = regB_q;
    regOp_d  = regOp_q;
    result_d = result_q;
    error_d  = error_q;
    case (state_q)
      S_A: begin
        if (!bus.undo && bus.enter) begin
          regA_d  = bus.data_in;
          state_d = S_B;
        end
      end
      S_B: begin
        if (bus.undo) begin
          state_d = S_A;
        end else if (bus.enter) begin
          regB_d  = bus.data_in;
          state_d = S_OP;
        end
      end
      S_OP: begin
        if (bus.undo) begin
          state_d = S_B;
        end else if (bus.enter && opOneHot) begin
          regOp_d = bus.op_sel;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = bus.alu_resultado;
        error_d  = bus.alu_overflow | bus.alu_underflow;
        state_d  = S_SHOW;
      end
      S_SHOW: begin
        if (bus.undo || (bus.enter && error_q)) begin
          result_d = '0;
          error_d  = 1'b0;
          state_d  = S_A;
        end else if (bus.enter) begin
          regA_d  = result_q;
          state_d = S_B;
        end
      end
      default: begin
        state_d = S_A;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_A;
      regA_q   <= '0;
      regB_q   <= '0;
      regOp_q  <= 4'd0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      regA_q   <= regA_d;
      regB_q   <= regB_d;
      regOp_q  <= regOp_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  // Outputs are decodes of registered state only; data_in just passes through for display
  assign bus.alu_button   = (state_q == S_EXEC) ? regOp_q : 4'd0;
  assign bus.alu_a        = regA_q;
  assign bus.alu_b        = regB_q;
  assign bus.result       = result_q;
  assign bus.error        = error_q;
  assign bus.result_valid = (state_q == S_SHOW) && !error_q;
  assign bus.state_out    = state_q;

  always_comb begin
    case (state_q)
      S_A, S_B:       bus.display_value = bus.data_in;
      S_OP:           bus.display_value = regB_q;
      S_EXEC, S_SHOW: bus.display_value = result_q;
      default:        bus.display_value = '0;
    endcase
  end

endmodule
